// File: rtl/mem_loader.sv
// Streams words into NUM_CH BRAM write ports in channel order and stalls the CPU until loading ends.
// Optional MEM_LOADER_CHECKSUM_EN adds a trailing checksum beat verified before release.
module mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CH*CNT_WIDTH-1:0]    word_cnt,
  input  logic                           s_valid,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           s_ready,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   w_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0]   w_dat,
  output logic [NUM_CH-1:0]              w_enb,
  output logic                           cpu_stall,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int          IDX_W = ADDR_WIDTH - 2;
  localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] LIMIT = 32'd1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]                   ch_q, ch_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;

  logic              hs;
  logic              start_go;
  logic              in_over;
  logic [NUM_CH-1:0] in_nz;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              has_next;
  logic              last_in_ch;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
`endif

  // s_ready is only ever high in LOAD or CHECK, so hs alone identifies an accepted beat.
  assign hs       = s_valid && s_ready;
  assign start_go = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  // Decode of the incoming counts and of the channel walk order.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    in_over  = 1'b0;
    in_nz    = '0;
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_nz[k] = (word_cnt[k*CNT_WIDTH +: CNT_WIDTH] != '0);
      if (32'(word_cnt[k*CNT_WIDTH +: CNT_WIDTH]) > LIMIT) in_over = 1'b1;
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (in_nz[k]) first_ch = CH_W'(k);
      if (k > int'(ch_q) && cnt_q[k] != '0) begin
        next_ch  = CH_W'(k);
        has_next = 1'b1;
      end
    end
    // idx is one bit too narrow to hold a full count, so compare in 32 bits.
    last_in_ch = ((32'(idx_q) + 32'd1) == 32'(cnt_q[ch_q]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          for (int k = 0; k < NUM_CH; k++) cnt_d[k] = word_cnt[k*CNT_WIDTH +: CNT_WIDTH];
          ch_d  = first_ch;
          idx_d = '0;
          if (in_over) begin
            state_d = S_ERROR;
          end else if (in_nz == '0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (last_in_ch) begin
            idx_d = '0;
            if (has_next) begin
              ch_d = next_ch;
            end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_FLUSH;
`endif
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_CHECK: begin
`ifdef MEM_LOADER_CHECKSUM_EN
        if (hs) state_d = (s_data == sum_q) ? S_DONE : S_ERROR;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and status flags; flags are decoded from the next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      idx_q     <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_stall <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      s_ready   <= (state_d == S_LOAD) || (state_d == S_CHECK);
      busy      <= (state_d == S_LOAD) || (state_d == S_FLUSH) || (state_d == S_CHECK);
      done      <= (state_d == S_DONE);
      err       <= (state_d == S_ERROR);
      cpu_stall <= (state_d != S_DONE);
    end
  end

  // Write port: one pulse per accepted data beat, one cycle after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: address and data registers are reset too, since they are visible outputs with defined reset values.
      w_enb  <= '0;
      w_addr <= '0;
      w_dat  <= '0;
    end else begin
      w_enb <= '0;
      if (hs && state_q == S_LOAD) begin
        w_enb[ch_q]                                  <= 1'b1;
        w_addr[int'(ch_q)*ADDR_WIDTH +: ADDR_WIDTH]  <= {idx_q, 2'b00};
        w_dat[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH]   <= s_data;
      end
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (start_go) begin
      sum_q <= '0;
    end else if (hs && state_q == S_LOAD) begin
      sum_q <= sum_q + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed and randomized bench for mem_loader with a write-list reference model built from the counts.
`timescale 1ns/1ps
module tb_mem_loader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NC = 2;
  localparam int CW = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NC*CW-1:0] word_cnt;
  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             s_ready;
  logic [NC*AW-1:0] w_addr;
  logic [NC*DW-1:0] w_dat;
  logic [NC-1:0]    w_enb;
  logic             cpu_stall;
  logic             busy;
  logic             done;
  logic             err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  bit  multi_hot = 1'b0;

  mem_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_CH    (NC),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .word_cnt (word_cnt),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .w_addr   (w_addr),
    .w_dat    (w_dat),
    .w_enb    (w_enb),
    .cpu_stall(cpu_stall),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Records every write pulse, one entry per cycle per enabled channel.
  always @(negedge clk) begin
    if ($countones(w_enb) > 1) multi_hot = 1'b1;
    for (int k = 0; k < NC; k++)
      if (w_enb[k]) obs_q.push_back('{ch: k, addr: w_addr[k*AW +: AW], dat: w_dat[k*DW +: DW]});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*CW-1:0] pack(input int c0, input int c1);
    return {CW'(c1), CW'(c0)};
  endfunction

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr%0d_ch", tag, i),   64'(obs_q[i].ch),   64'(exp_q[i].ch));
      check($sformatf("%s_wr%0d_addr", tag, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_wr%0d_dat", tag, i),  64'(obs_q[i].dat),  64'(exp_q[i].dat));
    end
    check({tag, "_onehot"}, 64'(multi_hot), 64'(0));
  endtask

  // One complete load: gap = idle cycles between beats, poke = beat index at which a stray start is pulsed.
  task automatic run_load(input string tag, input int c0, input int c1, input int gap,
                          input int poke, input bit ramp, input bit bad_sum);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    int            cnts[NC];
    int            total, sent, wait_cnt, budget;
    bit            ready_ok, hs_now;
    cnts[0] = c0;
    cnts[1] = c1;
    sum = '0;
    exp_q.delete();
    for (int ch = 0; ch < NC; ch++)
      for (int i = 0; i < cnts[ch]; i++) begin
        w = ramp ? DW'(words.size() + 1) : DW'($urandom);
        words.push_back(w);
        exp_q.push_back('{ch: ch, addr: AW'(i * 4), dat: w});
        sum += w;
      end
    total = words.size();

    obs_q.delete();
    multi_hot = 1'b0;
    word_cnt  = pack(c0, c1);
    start     = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_stall"}, 64'(cpu_stall), 64'(1));
    check({tag, "_start_busy"},  64'(busy),      64'(1));
    check({tag, "_start_done"},  64'(done),      64'(0));
    check({tag, "_start_err"},   64'(err),       64'(0));
    check({tag, "_start_ready"}, 64'(s_ready),   64'(1));

    sent     = 0;
    wait_cnt = 0;
    budget   = 0;
    ready_ok = 1'b1;
    while (sent < total && budget < 4 * total + 50) begin
      s_valid = (wait_cnt == 0);
      s_data  = words[sent];
      if (sent == poke && wait_cnt == 0) begin
        start    = 1'b1;
        word_cnt = pack(1, 1);
      end
      if (!s_ready) ready_ok = 1'b0;
      hs_now = s_valid && s_ready;
      tick();
      start = 1'b0;
      if (hs_now) begin
        sent++;
        wait_cnt = gap;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      budget++;
    end
    s_valid = 1'b0;
    check({tag, "_hs_count"},   64'(sent),     64'(total));
    check({tag, "_ready_held"}, 64'(ready_ok), 64'(1));

`ifdef MEM_LOADER_CHECKSUM_EN
    check({tag, "_chk_ready"}, 64'(s_ready),   64'(1));
    check({tag, "_chk_stall"}, 64'(cpu_stall), 64'(1));
    s_valid = 1'b1;
    s_data  = bad_sum ? sum + 1'b1 : sum;
    tick();
    s_valid = 1'b0;
    check({tag, "_end_stall"}, 64'(cpu_stall), 64'(bad_sum ? 1 : 0));
    check({tag, "_end_done"},  64'(done),      64'(bad_sum ? 0 : 1));
    check({tag, "_end_err"},   64'(err),       64'(bad_sum ? 1 : 0));
`else
    check({tag, "_t1_ready"}, 64'(s_ready),   64'(0));
    check({tag, "_t1_stall"}, 64'(cpu_stall), 64'(1));
    check({tag, "_t1_busy"},  64'(busy),      64'(1));
    tick();
    check({tag, "_t2_stall"}, 64'(cpu_stall), 64'(0));
    check({tag, "_t2_done"},  64'(done),      64'(1));
    check({tag, "_t2_busy"},  64'(busy),      64'(0));
    check({tag, "_t2_err"},   64'(err),       64'(0));
    check({tag, "_t2_ready"}, 64'(s_ready),   64'(0));
`endif
    tick();
    compare_writes(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(s_ready),   64'(0));
    check({tag, "_busy"},  64'(busy),      64'(0));
    check({tag, "_done"},  64'(done),      64'(0));
    check({tag, "_err"},   64'(err),       64'(0));
    check({tag, "_stall"}, 64'(cpu_stall), 64'(1));
    check({tag, "_enb"},   64'(w_enb),     64'(0));
    check({tag, "_addr"},  64'(w_addr),    64'(0));
    check({tag, "_dat"},   64'(w_dat),     64'(0));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    word_cnt = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    repeat (2) tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();
    check("idle_stall", 64'(cpu_stall), 64'(1));
    check("idle_ready", 64'(s_ready),   64'(0));

    // Basic load, then restart from DONE with a stray start in the middle of the stream.
    run_load("basic",   14, 4, 0, -1, 1'b0, 1'b0);
    run_load("restart", 14, 4, 0,  7, 1'b0, 1'b0);
    run_load("throttle", 3, 2, 2, -1, 1'b0, 1'b0);
    run_load("zero_ch0", 0, 5, 0, -1, 1'b0, 1'b0);
    run_load("limit",  256, 1, 0, -1, 1'b0, 1'b0);

    // Over-limit count goes straight to ERROR and accepts nothing.
    word_cnt = pack(257, 1);
    start    = 1'b1;
    tick();
    start = 1'b0;
    obs_q.delete();
    check("ovr_err",   64'(err),       64'(1));
    check("ovr_stall", 64'(cpu_stall), 64'(1));
    check("ovr_done",  64'(done),      64'(0));
    check("ovr_busy",  64'(busy),      64'(0));
    check("ovr_ready", 64'(s_ready),   64'(0));
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (3) tick();
    s_valid = 1'b0;
    check("ovr_nowrite", 64'(obs_q.size()), 64'(0));
    check("ovr_hold",    64'(err),          64'(1));

    // Recovery from ERROR.
    run_load("from_err", 1, 1, 0, -1, 1'b0, 1'b0);

    // Reset after 6 of 14 words.
    obs_q.delete();
    word_cnt = pack(14, 4);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check_reset_values("midrst");
    check("midrst_writes", 64'(obs_q.size()), 64'(5));
    tick();
    rst = 1'b0;
    tick();
    run_load("after_rst", 2, 0, 0, -1, 1'b0, 1'b0);

    // Randomized counts and pacing.
    for (int r = 0; r < 4; r++)
      run_load($sformatf("rnd%0d", r), int'($urandom_range(20, 1)), int'($urandom_range(20, 0)),
               int'($urandom_range(2, 0)), -1, 1'b0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
    run_load("sum_ok",  3, 0, 0, -1, 1'b1, 1'b0);
    run_load("sum_bad", 3, 0, 0, -1, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Parametrised hardware memory preloader for the rv32i single-core CPU. It accepts a word stream over a valid/ready handshake, distributes the words in order into `NUM_CH` BRAM write ports (channel 0 = instruction BRAM, channel 1 = data BRAM), and holds the PC stalled until every channel is loaded. It replaces the per-bench loading loops with one synthesizable block. It sits between the external load source (UART/AXI bridge or bench) and the write ports of the `bram32` instances, and drives the `pc` stall input.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width of stream and BRAM write data
- `ADDR_WIDTH`, 10, BRAM byte-address width
- `NUM_CH`, 2, number of target memories (≥1)
- `CNT_WIDTH`, 9, width of each per-channel word count

Ports (reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- `word_cnt`  in  NUM_CH*CNT_WIDTH  words per channel; channel k is `[k*CNT_WIDTH +: CNT_WIDTH]`; sampled on `start`
- `s_valid`  in  1  stream word valid
- `s_data`  in  DATA_WIDTH  stream word
- `s_ready`  out  1  loader accepts a word this cycle
- `w_addr`  out  NUM_CH*ADDR_WIDTH  per-channel BRAM byte address
- `w_dat`  out  NUM_CH*DATA_WIDTH  per-channel BRAM write data
- `w_enb`  out  NUM_CH  per-channel write enable (one-hot or zero)
- `cpu_stall`  out  1  drives `pc.stall`
- `busy`  out  1  load in progress
- `done`  out  1  all channels loaded
- `err`  out  1  load aborted

## Operation
- States: IDLE, LOAD, FLUSH, CHECK (macro only), DONE, ERROR.
- Reset values: state = IDLE, `cpu_stall` = 1, `s_ready`, `busy`, `done`, `err`, and `w_enb` = 0, and `w_addr` / `w_dat` = 0.
- IDLE/DONE/ERROR + `start`:
  - Latch the counts and clear `err` and `done`.
  - If any count exceeds 2^(ADDR_WIDTH-2), go to ERROR.
  - Else if all counts are 0, go to DONE (or to CHECK when the macro is defined).
  - Else go to LOAD at the lowest channel with a nonzero count, with index 0.
- LOAD:
  - `s_ready` = 1, `busy` = 1.
  - Each handshake (`s_valid && s_ready`) writes `s_data` to channel `ch` at byte address `idx*4`.
  - Increment `idx`. When `idx` reaches `word_cnt[ch]`, advance to the next channel with a nonzero count and reset `idx` to 0.
  - Channels with a count of 0 are skipped and never receive a `w_enb` pulse.
  - The handshake of the last word of the last channel moves the block to FLUSH (or CHECK).
- FLUSH: one cycle in which the final write pulse is emitted, then DONE.
- DONE: `cpu_stall` = 0, `done` = 1. Holds until `start` or `rst`.
- ERROR: `err` = 1, `cpu_stall` = 1. Holds until `start` or `rst`.
- `start` while in LOAD or FLUSH is ignored.
- Address arithmetic: `idx` is `ADDR_WIDTH-2` bits wide and `w_addr = {idx, 2'b00}`. The count limit guarantees no wrap-around.
- On `rst` mid-load: return immediately to the reset values. Partially written BRAM contents remain and the CPU stays stalled.

## Timing
- Write latency: a handshake at cycle t gives `w_enb[ch]` = 1 with `w_addr`/`w_dat` valid at t+1, for exactly one cycle.
- `s_ready` stays high across channel boundaries, so one word per cycle is sustained with no bubble.
- `s_ready` drops at t+1 after the last handshake (non-macro build).
- `cpu_stall` deasserts at t+2 after the last data handshake. This is one cycle after the final `w_enb`, so the BRAM is written before the first fetch.
- A `start` pulse in DONE reasserts `cpu_stall` on the next cycle.
- All outputs are registered.

## Configuration
- Macro: `MEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running sum mod 2^DATA_WIDTH is kept over all accepted data words.
  - After the last data word the block enters CHECK with `s_ready` = 1. The next beat is the checksum.
  - On a match, go to DONE on the next cycle. On a mismatch, go to ERROR on the next cycle.
  - The final data write still completes. CHECK lasts at least one cycle, so `cpu_stall` release stays at or after t+2.
  - With all counts 0, the expected checksum is 0.
- Undefined: no CHECK state and no accumulator. The block goes LOAD → FLUSH → DONE.

## Test plan
- **Basic load:** counts {ch0 = 14, ch1 = 4}, back-to-back `s_valid` → 14 single-cycle `w_enb[0]` pulses at addresses 0x000..0x034, then 4 `w_enb[1]` pulses at 0x000..0x00C. `cpu_stall` falls 2 cycles after the 18th handshake and `done` = 1.
- **Throttled stream:** `s_valid` high every third cycle, counts {3, 2} → identical write sequence with no extra or dropped pulses. `s_ready` stays 1 throughout LOAD.
- **Zero and limit counts:**
  - {0, 5} → no `w_enb[0]` pulses; 5 writes to ch1.
  - {257, 1} with `ADDR_WIDTH` = 10 → ERROR the cycle after `start`, `err` = 1, `cpu_stall` = 1, no writes.
- **Reset mid-load:** assert `rst` after 6 of 14 words → all outputs return to reset values immediately. A new `start` with counts {2, 0} completes normally.
- **Restart and ignored start:** `start` in DONE → `cpu_stall` = 1 the next cycle and the load repeats. A `start` pulse during LOAD has no effect.
- **Checksum (macro defined):** words 1, 2, 3 plus checksum 6 → DONE. The same words with checksum 7 → ERROR, `err` = 1, while the 3 data writes still occur.
